// File: rtl/wishbone_initiator_bfm_pkg.sv
// wishbone_initiator_bfm_pkg: shared types, constants and the foreign-code API handle for the Wishbone initiator BFM.
// Request fields are sized for the widest supported bus (64-bit address and data).
package wishbone_initiator_bfm_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic [63:0] adr;
    logic [63:0] dat;
    logic [7:0]  sel;
    logic        we;
  } req_t;
  localparam int TIMEOUT_CYCLES = 1024;
`ifndef SYNTHESIS
  class wb_init_api;
    chandle m_obj;
  endclass
`endif
endpackage

// File: rtl/wishbone_initiator_bfm.sv
// wishbone_initiator_bfm: Wishbone B3 classic initiator; each read/write task call becomes one bus cycle.
// Define WB_INIT_BFM_TIMEOUT_EN to abort cycles that see no ack/err within TIMEOUT_CYCLES clocks.
module wishbone_initiator_bfm
  import wishbone_initiator_bfm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDR_WIDTH-1:0]   adr,
  output logic [DATA_WIDTH-1:0]   dat_w,
  input  logic [DATA_WIDTH-1:0]   dat_r,
  output logic [DATA_WIDTH/8-1:0] sel,
  output logic                    we,
  output logic                    cyc,
  output logic                    stb,
  input  logic                    ack,
  input  logic                    err
);
  localparam int SW = DATA_WIDTH / 8;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_w_q, rsp_dat_q;
  logic [SW-1:0]         sel_q;
  logic                  we_q, cyc_q, rsp_err_q, done_q, tmo_hit;
  logic                  unused_req;
`ifdef SYNTHESIS
  req_t req;
  logic req_pend;
  assign req      = '0;
  assign req_pend = 1'b0;
`else
  req_t        req = '0;
  logic        req_pend = 1'b0;
  int unsigned tkt_next = 0;
  int unsigned tkt_srv = 0;
  wb_init_api  m_api_obj;
  // Ticket lock: callers are served strictly in arrival order, one bus cycle at a time.
  task automatic xfer(input req_t r, output logic [DATA_WIDTH-1:0] dat_o, output logic err_o);
    int unsigned t;
    if (m_api_obj == null) m_api_obj = new();
    t = tkt_next;
    tkt_next++;
    wait (tkt_srv == t);
    wait (reset == 1'b0);
    req = r;
    req_pend = 1'b1;
    @(posedge done_q);
    req_pend = 1'b0;
    dat_o = rsp_dat_q;
    err_o = rsp_err_q;
    tkt_srv++;
  endtask
  task automatic write(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d,
                       input logic [SW-1:0] s, output logic err_o);
    logic [DATA_WIDTH-1:0] unused_dat;
    xfer('{adr: 64'(a), dat: 64'(d), sel: 8'(s), we: 1'b1}, unused_dat, err_o);
  endtask
  task automatic read(input logic [ADDR_WIDTH-1:0] a, output logic [DATA_WIDTH-1:0] dat_o,
                      output logic err_o);
    xfer('{adr: 64'(a), dat: 64'd0, sel: 8'({SW{1'b1}}), we: 1'b0}, dat_o, err_o);
  endtask
`endif
  assign unused_req = ^req;
`ifdef WB_INIT_BFM_TIMEOUT_EN
  logic [15:0] tmo_q;
  assign tmo_hit = state_q == BUSY && !ack && !err && tmo_q == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    tmo_q <= reset || state_q != BUSY ? '0 : tmo_q + 16'd1;
    if (!reset && tmo_hit) $error("wishbone_initiator_bfm: no ack/err after %0d cycles, aborting", TIMEOUT_CYCLES);
  end
`else
  assign tmo_hit = 1'b0;
`endif
  // done_q pulses for one cycle after every termination (including reset of a live cycle) to wake the caller.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_w_q   <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b1;
      done_q    <= state_q == BUSY;
    end else if (state_q == IDLE) begin
      state_q <= req_pend ? BUSY : IDLE;
      cyc_q   <= req_pend;
      we_q    <= req_pend & req.we;
      adr_q   <= req_pend ? req.adr[ADDR_WIDTH-1:0] : '0;
      sel_q   <= req_pend ? req.sel[SW-1:0] : '0;
      dat_w_q <= req_pend && req.we ? req.dat[DATA_WIDTH-1:0] : '0;
      done_q  <= 1'b0;
    end else if (ack || err || tmo_hit) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_w_q   <= '0;
      rsp_dat_q <= we_q || tmo_hit ? '0 : dat_r;
      rsp_err_q <= err || tmo_hit;
      done_q    <= 1'b1;
    end
  end
  assign adr   = adr_q;
  assign dat_w = dat_w_q;
  assign sel   = sel_q;
  assign we    = we_q;
  assign cyc   = cyc_q;
  assign stb   = cyc_q;
endmodule

// File: tb/tb_wishbone_initiator_bfm.sv
// tb_wishbone_initiator_bfm: randomized scoreboard bench for the Wishbone initiator BFM.
module tb_wishbone_initiator_bfm;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err;
  always #5 clk = ~clk;
  wishbone_initiator_bfm dut (
    .clk(clk), .reset(reset), .adr(adr), .dat_w(dat_w), .dat_r(dat_r), .sel(sel),
    .we(we), .cyc(cyc), .stb(stb), .ack(ack), .err(err)
  );
  int          tgt_delay = 0;
  bit          tgt_err = 0, tgt_both = 0, tgt_loop = 0;
  logic [31:0] tgt_rdata = '0;
  int          wcnt = 0;
  assign ack   = cyc && stb && wcnt >= tgt_delay && (!tgt_err || tgt_both);
  assign err   = cyc && stb && wcnt >= tgt_delay && tgt_err;
  assign dat_r = tgt_loop ? dat_w : tgt_rdata;
  always @(posedge clk) wcnt <= (cyc && !ack && !err) ? wcnt + 1 : 0;
  time t_pos;
  always @(posedge clk) t_pos = $time;
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          len;
  } bus_t;
  bus_t exp_q[$];
  int checks = 0, failures = 0;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction
  bus_t cur, e;
  bit   in_cyc = 0, stable = 0;
  int   len = 0;
  always @(negedge clk) begin
    if (cyc) begin
      if (!in_cyc) begin
        in_cyc = 1;
        cur.adr = adr; cur.dat = dat_w; cur.sel = sel; cur.we = we;
        stable = stb;
        len = 0;
      end else if ({adr, dat_w, sel, we, stb} !== {cur.adr, cur.dat, cur.sel, cur.we, 1'b1}) stable = 0;
      len++;
    end else if (in_cyc) begin
      in_cyc = 0;
      chk("bus_stable", stable, 1);
      chk("idle_adr", adr, 0);
      chk("idle_dat", dat_w, 0);
      chk("idle_ctl", {sel, we, stb}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cycle: adr %0h with no call outstanding", cur.adr);
      end else begin
        e = exp_q.pop_front();
        chk("bus_adr", cur.adr, e.adr);
        chk("bus_dat", cur.dat, e.dat);
        chk("bus_sel", cur.sel, e.sel);
        chk("bus_we", cur.we, e.we);
        if (e.len != 0) chk("bus_len", len, e.len);
      end
    end
  end
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int dly, input bit e_in, input bit both);
    logic er;
    tgt_delay = dly; tgt_err = e_in; tgt_both = both; tgt_loop = 0;
    exp_q.push_back('{adr: a, dat: d, sel: s, we: 1'b1, len: dly + 1});
    dut.write(a, d, s, er);
    chk("wr_err", er, e_in);
    chk("wr_ret_edge", $time, t_pos);
  endtask
  task automatic do_read(input logic [31:0] a, input logic [31:0] rdata, input bit loop,
                         input int dly, input bit e_in, input bit both);
    logic [31:0] d;
    logic er;
    tgt_delay = dly; tgt_err = e_in; tgt_both = both; tgt_loop = loop; tgt_rdata = rdata;
    exp_q.push_back('{adr: a, dat: 32'h0, sel: 4'hF, we: 1'b0, len: dly + 1});
    dut.read(a, d, er);
    chk("rd_err", er, e_in);
    chk("rd_dat", d, loop ? 32'h0 : rdata);
    chk("rd_ret_edge", $time, t_pos);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [31:0] d;
    logic e1, e2;
    repeat (5) @(negedge clk);
    reset = 0;
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_w, 0);
    chk("rst_ctl", {sel, we, cyc, stb}, 0);
    do_write(32'h1000, 32'hDEADBEEF, 4'hF, 1, 0, 0);
    @(negedge clk);
    do_read(32'h2000, 32'hFFFF_FFFF, 1, 1, 0, 0);
    @(negedge clk);
    do_read(32'h3000, 32'h12345678, 0, 0, 0, 0);
    @(negedge clk);
    do_write(32'h4, 32'h1, 4'h1, 1, 1, 0);
    do_write(32'h8, 32'h2, 4'h2, 0, 1, 1);
    @(negedge clk);
    tgt_delay = 0; tgt_err = 0; tgt_both = 0;
    exp_q.push_back('{adr: 32'h10, dat: 32'hA, sel: 4'h3, we: 1'b1, len: 1});
    exp_q.push_back('{adr: 32'h14, dat: 32'hB, sel: 4'hC, we: 1'b1, len: 1});
    fork
      dut.write(32'h10, 32'hA, 4'h3, e1);
      begin #1 dut.write(32'h14, 32'hB, 4'hC, e2); end
    join
    chk("b2b_err1", e1, 0);
    chk("b2b_err2", e2, 0);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rd;
      int dly;
      bit re, rb;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = $urandom; rd = $urandom;
      dly = $urandom_range(0, 3);
      re = $urandom_range(0, 3) == 0;
      rb = re && $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) do_write(ra, rd, 4'($urandom_range(0, 15)), dly, re, rb);
      else do_read(ra, rd, $urandom_range(0, 4) == 0, dly, re, rb);
    end
    @(negedge clk);
    reset = 1;
    tgt_delay = 0; tgt_err = 0; tgt_both = 0; tgt_loop = 0;
    exp_q.push_back('{adr: 32'h60, dat: 32'h66, sel: 4'h9, we: 1'b1, len: 1});
    fork
      dut.write(32'h60, 32'h66, 4'h9, e1);
      begin
        repeat (3) @(negedge clk);
        chk("no_cyc_in_reset", cyc, 0);
        reset = 0;
      end
    join
    chk("held_call_err", e1, 0);
    @(negedge clk);
    tgt_delay = 100000; tgt_rdata = 32'hCAFE_F00D;
    exp_q.push_back('{adr: 32'h50, dat: 32'h0, sel: 4'hF, we: 1'b0, len: 0});
    fork
      dut.read(32'h50, d, e1);
      begin
        repeat (4) @(negedge clk);
        chk("busy_before_rst", cyc, 1);
        reset = 1;
        @(negedge clk);
        chk("rst_busy_adr", adr, 0);
        chk("rst_busy_ctl", {sel, we, cyc, stb}, 0);
        reset = 0;
      end
    join
    chk("rst_busy_err", e1, 1);
    chk("rst_busy_dat", d, 0);
`ifdef WB_INIT_BFM_TIMEOUT_EN
    @(negedge clk);
    tgt_delay = 100000;
    exp_q.push_back('{adr: 32'h70, dat: 32'h0, sel: 4'hF, we: 1'b0, len: 1024});
    dut.read(32'h70, d, e1);
    chk("tmo_err", e1, 1);
    chk("tmo_dat", d, 0);
`endif
    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
